opram_sp: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the fixed 256x8 operand RAM. It adds configurable width and depth, three write modes, an optional oce-gated output register, and a hardware clear sequencer that fills the array after reset. It sits beside the core datapath as operand/scratch storage. It is pure behavioural RTL and infers a block RAM.

---
 rtl/opram_sp.sv | 130 +++++++++++++
 tb/tb_opram_sp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/opram_sp.sv
// Parametrised single-port synchronous RAM with selectable write mode, optional
// oce-gated output register and a post-reset clear sequencer.
module opram_sp #(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       OUT_REG        = 1,
  parameter int unsigned       WRITE_MODE     = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic [1:0] {S1_HOLD, S1_MEM, S1_DIN} s1_sel_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  s1_sel_t           s1_sel;
  logic              s1_valid_d;
  logic [DATA_W-1:0] stage1;
  logic              s1_valid;

  // State, clear counter and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_q   <= '0;
      busy    <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      busy    <= (state_d == CLEAR);
    end
  end

  // Next state, array write port and stage1 load selection
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    mem_we     = 1'b0;
    mem_wa     = ad;
    mem_wd     = din;
    s1_sel     = S1_HOLD;
    s1_valid_d = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_q;
        mem_wd = CLEAR_VALUE;
        clr_d  = ADDR_W'(clr_q + 1'b1);
        if (clr_q == {ADDR_W{1'b1}}) state_d = RUN;
      end
      RUN: begin
        if (ce) begin
          mem_we = wre;
          if (!wre) begin
            s1_sel     = S1_MEM;
            s1_valid_d = 1'b1;
          end else if (WRITE_MODE == 1) begin
            s1_sel     = S1_DIN;
            s1_valid_d = 1'b1;
          end else if (WRITE_MODE == 2) begin
            s1_sel     = S1_MEM;
            s1_valid_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Array: reset never writes, so a reset cycle drops any access
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= mem_wd;
  end

  // First output stage; a read of the written address returns the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid_d;
      case (s1_sel)
        S1_MEM:  stage1 <= mem[ad];
        S1_DIN:  stage1 <= din;
        default: stage1 <= stage1;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          dout     <= '0;
          rd_valid <= 1'b0;
        end else if (oce) begin
          dout     <= stage1;
          rd_valid <= s1_valid;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end else begin : g_no_out_reg
      logic unused_oce;
      assign unused_oce = oce;
      assign dout       = stage1;
      assign rd_valid   = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_opram_sp.sv
// Directed bench for opram_sp: three instances (write modes 0/1/2, with and
// without the output register) share one stimulus stream.
module tb_opram_sp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0, oce = 1'b1, wre = 1'b0;
  logic [7:0] ad = 8'h00, din = 8'h00;

  logic [7:0] dout0, dout1, dout2;
  logic       rv0, rv1, rv2, busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opram_sp #(.DATA_W(8), .ADDR_W(8), .OUT_REG(1), .WRITE_MODE(0),
             .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_m0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .dout(dout0), .rd_valid(rv0), .busy(busy0));

  opram_sp #(.DATA_W(8), .ADDR_W(8), .OUT_REG(0), .WRITE_MODE(1),
             .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_m1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .dout(dout1), .rd_valid(rv1), .busy(busy1));

  opram_sp #(.DATA_W(8), .ADDR_W(8), .OUT_REG(0), .WRITE_MODE(2),
             .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_m2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad),
    .din(din), .dout(dout2), .rd_valid(rv2), .busy(busy2));

  typedef struct {
    logic       ce, wre, oce;
    logic [7:0] ad, din;
    logic [7:0] d0; logic r0;
    logic [7:0] d1; logic r1;
    logic [7:0] d2; logic r2;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles busy stays high, counted from the sample after the reset edge
  task automatic wait_clear(output int n, output logic rv_seen);
    n = 0;
    rv_seen = 1'b0;
    while (busy0 && n < 1000) begin
      n++;
      if (rv0 || rv1 || rv2) rv_seen = 1'b1;
      tick();
    end
  endtask

  initial begin
    int n;
    logic rv_seen;
    int bad0, bad1, bad2;

    //          ce    wre   oce   ad     din    d0     r0    d1     r1    d2     r2
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h7F, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h3C, 8'hA5, 1'b0, 8'h3C, 1'b1, 8'hA5, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'hA5, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h20, 8'h11, 8'h3C, 1'b0, 8'h11, 1'b1, 8'hA5, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h11, 1'b0, 8'hA5, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h20, 8'h22, 8'h3C, 1'b0, 8'h22, 1'b1, 8'h11, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 8'h3C, 1'b0, 8'h22, 1'b1, 8'h22, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h22, 1'b1, 8'h22, 1'b0, 8'h22, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h22, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h22, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h22, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 8'hC8, 8'h5A, 8'h3C, 1'b0, 8'h5A, 1'b1, 8'hA5, 1'b1};

    // Reset together with a write: reset wins, clear begins
    reset = 1'b1; ce = 1'b1; wre = 1'b1; ad = 8'h05; din = 8'hEE;
    tick();
    check("reset_dout0", 32'(dout0), 32'h00);
    check("reset_dout1", 32'(dout1), 32'h00);
    check("reset_rv", 32'({rv0, rv1, rv2}), 32'h0);
    check("reset_busy", 32'({busy0, busy1, busy2}), 32'h7);

    // Writes keep being offered while the clear runs
    reset = 1'b0;
    wait_clear(n, rv_seen);
    ce = 1'b0; wre = 1'b0;
    check("clear_cycles", 32'(n), 32'd256);
    check("clear_no_rd_valid", 32'(rv_seen), 32'h0);
    check("clear_busy_all_low", 32'({busy0, busy1, busy2}), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      ce = vecs[i].ce; wre = vecs[i].wre; oce = vecs[i].oce;
      ad = vecs[i].ad; din = vecs[i].din;
      tick();
      check($sformatf("v%0d_dout0", i), 32'(dout0), 32'(vecs[i].d0));
      check($sformatf("v%0d_rv0", i), 32'(rv0), 32'(vecs[i].r0));
      check($sformatf("v%0d_dout1", i), 32'(dout1), 32'(vecs[i].d1));
      check($sformatf("v%0d_rv1", i), 32'(rv1), 32'(vecs[i].r1));
      check($sformatf("v%0d_dout2", i), 32'(dout2), 32'(vecs[i].d2));
      check($sformatf("v%0d_rv2", i), 32'(rv2), 32'(vecs[i].r2));
      check($sformatf("v%0d_busy", i), 32'(busy0), 32'h0);
    end
    ce = 1'b0; wre = 1'b0; oce = 1'b1;

    // Reset, then reset again once clr_cnt has reached 100
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midclear_busy_before", 32'(busy0), 32'h1);
    reset = 1'b1;
    tick();
    check("midclear_reset_dout0", 32'(dout0), 32'h00);
    check("midclear_reset_busy", 32'(busy0), 32'h1);
    reset = 1'b0;
    wait_clear(n, rv_seen);
    check("midclear_cycles", 32'(n), 32'd256);
    check("midclear_no_rd_valid", 32'(rv_seen), 32'h0);

    // Sweep every address at full rate; m0 lags by one cycle
    bad0 = 0; bad1 = 0; bad2 = 0;
    for (int a = 0; a < 256; a++) begin
      ce = 1'b1; wre = 1'b0; ad = 8'(a);
      tick();
      if (dout1 !== 8'hA5 || rv1 !== 1'b1) bad1++;
      if (dout2 !== 8'hA5 || rv2 !== 1'b1) bad2++;
      if (a > 0 && (dout0 !== 8'hA5 || rv0 !== 1'b1)) bad0++;
    end
    ce = 1'b0;
    check("sweep_bad_m0", 32'(bad0), 32'd0);
    check("sweep_bad_m1", 32'(bad1), 32'd0);
    check("sweep_bad_m2", 32'(bad2), 32'd0);
    tick();
    check("sweep_last_m0", 32'({rv0, dout0}), 32'h1A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
